// File: rtl/axi_txn_throttle_pkg.sv
// Shared types and helpers for the AXI transaction throttle.
// - AXI4+ATOP channel payload structs and the default request/response
//   bundles used on the throttle's slave and master ports.
// - cnt_width(): width needed to hold 0..max(a,b) inclusive.
package axi_txn_throttle_pkg;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [5:0]  atop;
    } aw_chan_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
    } w_chan_t;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } b_chan_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } ar_chan_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } axi_req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        b_chan_t b;
        logic    r_valid;
        r_chan_t r;
    } axi_resp_t;

    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

endpackage

// File: rtl/axi_txn_throttle_cnt.sv
// Up/down outstanding-transaction counter.
// - clk_i, rst_i : clock, synchronous active-high reset
// - inc          : increment amount (0..2) this cycle
// - dec          : decrement by one this cycle
// - q            : current count (registered)
// - underflow    : pulses when a decrement hits an empty counter with no
//                  matching increment; the counter then holds at 0
module axi_txn_cnt #(
    parameter int unsigned Width = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [1:0]       inc,
    input  logic             dec,
    output logic [Width-1:0] q,
    output logic             underflow
);

    logic [Width-1:0] q_reg;
    logic [Width-1:0] q_next;

    assign underflow = dec & (q_reg == '0) & (inc == 2'd0);

    always_comb begin
        q_next = q_reg + Width'(inc) - Width'(dec);
        if (underflow) begin
            q_next = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_reg <= '0;
        end else begin
            q_reg <= q_next;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/axi_txn_throttle.sv
// AXI4+ATOP pass-through throttle.
// Caps outstanding writes/reads, holds W beats until their AW is accepted,
// and offers a drain/quiesce handshake. Payloads and B/R pass untouched.
// Ports:
// - clk_i, rst_i   : clock, synchronous active-high reset
// - drain_i        : 1 = stop new AW/AR and drain outstanding traffic
// - slv_req_i / slv_resp_o : upstream side
// - mst_req_o / mst_resp_i : downstream side
// - wr_cnt_o, rd_cnt_o     : outstanding write / read transactions
// - drained_o      : high while quiesced (IDLE)
// - err_o          : sticky counter-underflow (protocol) error
module axi_txn_throttle
    import axi_txn_throttle_pkg::*;
#(
    parameter int unsigned MaxWrTxns = 4,
    parameter int unsigned MaxRdTxns = 4,
    parameter type         req_t     = axi_req_t,
    parameter type         resp_t    = axi_resp_t,
    localparam int unsigned CntWidth = cnt_width(MaxWrTxns, MaxRdTxns)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                drain_i,
    input  req_t                slv_req_i,
    output resp_t               slv_resp_o,
    output req_t                mst_req_o,
    input  resp_t               mst_resp_i,
    output logic [CntWidth-1:0] wr_cnt_o,
    output logic [CntWidth-1:0] rd_cnt_o,
    output logic                drained_o,
    output logic                err_o
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_IDLE
    } state_e;

    localparam logic [CntWidth-1:0] MAX_WR   = CntWidth'(MaxWrTxns);
    localparam logic [CntWidth:0]   MAX_RD_W = (CntWidth + 1)'(MaxRdTxns);

    state_e state_reg, state_next;
    logic   err_reg;

    logic [CntWidth-1:0] wr_cnt, rd_cnt, w_pend;
    logic                wr_uf, rd_uf, wp_uf;

    logic aw_ok, ar_ok, w_ok;
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic aw_rd, rd_both, rd_room;
    logic [CntWidth:0] rd_need;

    // ------------------------------------------------------------------
    // Gating. Read room is checked for +2 when an R-bearing ATOP and an AR
    // are both offered, so neither can push rd_cnt past the cap.
    // ------------------------------------------------------------------
    assign aw_rd   = slv_req_i.aw.atop[5];
    assign rd_both = slv_req_i.aw_valid & aw_rd & slv_req_i.ar_valid;
    assign rd_need = rd_both ? (CntWidth + 1)'(2) : (CntWidth + 1)'(1);
    assign rd_room = ({1'b0, rd_cnt} + rd_need) <= MAX_RD_W;

    assign aw_ok = (state_reg == ST_RUN) & (wr_cnt < MAX_WR) & (w_pend < MAX_WR)
                 & (~aw_rd | rd_room);
    assign ar_ok = (state_reg == ST_RUN) & rd_room;

    assign aw_hs = slv_req_i.aw_valid & aw_ok & mst_resp_i.aw_ready;
    assign ar_hs = slv_req_i.ar_valid & ar_ok & mst_resp_i.ar_ready;

    // A beat waiting for its AW is released in the AW handshake cycle
    // itself, not one cycle later when w_pend has registered the AW.
    assign w_ok = (w_pend != '0) | aw_hs;

    assign w_hs = slv_req_i.w_valid & w_ok & mst_resp_i.w_ready;
    assign b_hs = mst_resp_i.b_valid & slv_req_i.b_ready;
    assign r_hs = mst_resp_i.r_valid & slv_req_i.r_ready;

    always_comb begin
        mst_req_o          = slv_req_i;
        mst_req_o.aw_valid = slv_req_i.aw_valid & aw_ok;
        mst_req_o.w_valid  = slv_req_i.w_valid & w_ok;
        mst_req_o.ar_valid = slv_req_i.ar_valid & ar_ok;

        slv_resp_o          = mst_resp_i;
        slv_resp_o.aw_ready = mst_resp_i.aw_ready & aw_ok;
        slv_resp_o.w_ready  = mst_resp_i.w_ready & w_ok;
        slv_resp_o.ar_ready = mst_resp_i.ar_ready & ar_ok;
    end

    // ------------------------------------------------------------------
    // Counters
    // ------------------------------------------------------------------
    axi_txn_cnt #(.Width(CntWidth)) u_wr_cnt (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .inc       ({1'b0, aw_hs}),
        .dec       (b_hs),
        .q         (wr_cnt),
        .underflow (wr_uf)
    );

    axi_txn_cnt #(.Width(CntWidth)) u_w_pend (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .inc       ({1'b0, aw_hs}),
        .dec       (w_hs & slv_req_i.w.last),
        .q         (w_pend),
        .underflow (wp_uf)
    );

    axi_txn_cnt #(.Width(CntWidth)) u_rd_cnt (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .inc       ({1'b0, ar_hs} + {1'b0, aw_hs & aw_rd}),
        .dec       (r_hs & mst_resp_i.r.last),
        .q         (rd_cnt),
        .underflow (rd_uf)
    );

    // ------------------------------------------------------------------
    // Drain FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= ST_RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_RUN: begin
                if (drain_i) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!drain_i) begin
                    state_next = ST_RUN;
                end else if ((wr_cnt == '0) && (rd_cnt == '0) && (w_pend == '0)
                             && !(aw_hs | w_hs | b_hs | ar_hs | r_hs)) begin
                    state_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (!drain_i) state_next = ST_RUN;
            end
            default: state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_reg <= 1'b0;
        end else if (wr_uf | rd_uf | wp_uf) begin
            err_reg <= 1'b1;
        end
    end

    assign wr_cnt_o  = wr_cnt;
    assign rd_cnt_o  = rd_cnt;
    assign drained_o = (state_reg == ST_IDLE);
    assign err_o     = err_reg;

endmodule
